// File: rtl/sha256_id_match_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_id_match_buf_if
// Description : ID input, reference ID and matched-ID output streams of the
//               SHA-256 ID match buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha256_id_match_buf_if #(
    parameter int ID_W = 6
);
    logic [ID_W-1:0] id_in;
    logic            id_in_last;
    logic            id_in_valid;
    logic            id_in_ready;

    logic [ID_W-1:0] ref_id;
    logic            ref_last;
    logic            ref_valid;
    logic            ref_ready;

    logic [ID_W-1:0] id_out;
    logic            id_out_last;
    logic            id_out_match;
    logic            id_out_valid;
    logic            id_out_ready;

    modport slave (
        input  id_in, id_in_last, id_in_valid,
        output id_in_ready,
        input  ref_id, ref_last, ref_valid,
        output ref_ready,
        output id_out, id_out_last, id_out_match, id_out_valid,
        input  id_out_ready
    );

    modport master (
        output id_in, id_in_last, id_in_valid,
        input  id_in_ready,
        output ref_id, ref_last, ref_valid,
        input  ref_ready,
        input  id_out, id_out_last, id_out_match, id_out_valid,
        output id_out_ready
    );
endinterface
`default_nettype wire

// File: rtl/sha256_id_match_buf.sv
`default_nettype none
// ============================================================================
// Module      : sha256_id_match_buf
// Description : DEPTH-entry ID FIFO whose head is joined with a reference ID
//               stream; emits each ID with a match flag and mismatch status.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_id_match_buf #(
    parameter int ID_W  = 6,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  wire logic                   clk,
    input  wire logic                   sync_rst,
    input  wire logic                   en,
    sha256_id_match_buf_if.slave        bus,
    output logic [ID_W-1:0]             status_id,
    output logic [$clog2(DEPTH):0]      status_level,
    output logic [CNT_W-1:0]            status_err_cnt,
    output logic                        status_err
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_LW   = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    logic [ID_W:0]      r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_LW-1:0]    r_level;
    logic [ID_W-1:0]    r_status_id;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_wr;
    logic               w_rd;
    logic [ID_W:0]      w_head;
    logic               w_match;

    assign w_full  = (r_level == c_FULL);
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_match = (w_head == {bus.ref_last, bus.ref_id});

    // Ready ignores a same-cycle pop: a full FIFO never accepts a write.
    assign bus.id_in_ready  = en & ~w_full & ~sync_rst;
    assign bus.id_out_valid = en & ~w_empty & bus.ref_valid & ~sync_rst;
    assign bus.ref_ready    = en & ~w_empty & bus.id_out_ready & ~sync_rst;

    assign bus.id_out       = w_head[ID_W-1:0];
    assign bus.id_out_last  = w_head[ID_W];
    assign bus.id_out_match = w_match;

    assign w_wr = bus.id_in_valid & bus.id_in_ready;
    assign w_rd = bus.id_out_valid & bus.id_out_ready;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {bus.id_in_last, bus.id_in};
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_status_id <= '0;
            r_err_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_wr && !w_rd) begin
                r_level <= r_level + c_LW'(1);
            end else if (!w_wr && w_rd) begin
                r_level <= r_level - c_LW'(1);
            end
            if (w_rd) begin
                r_status_id <= w_head[ID_W-1:0];
                if (!w_match) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != {CNT_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign status_id      = r_status_id;
    assign status_level   = r_level;
    assign status_err_cnt = r_err_cnt;
    assign status_err     = r_err;

endmodule
`default_nettype wire
